// File: rtl/lsu_if.sv
// Data-bus interface of the load/store unit: request channel plus response channel.
// Latency: n/a (wires only).
// Backpressure: the slave holds off a request by keeping dbus_req_ready low.
//
// Signals:
//   dbus_req_valid  master->slave  request valid
//   dbus_req_ready  slave->master  request accepted when valid & ready
//   dbus_write      master->slave  1 store, 0 load
//   dbus_addr       master->slave  word-aligned address
//   dbus_wdata      master->slave  byte-replicated store data
//   dbus_byte_en    master->slave  byte lane enables
//   dbus_rsp_valid  slave->master  load data / write ack, at least one cycle after acceptance
//   dbus_rdata      slave->master  load data word, valid with dbus_rsp_valid
// Modports: master = LSU, slave = memory / bus fabric.
interface lsu_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic                  dbus_req_valid;
   logic                  dbus_req_ready;
   logic                  dbus_write;
   logic [ADDR_WIDTH-1:0] dbus_addr;
   logic [31:0]           dbus_wdata;
   logic [3:0]            dbus_byte_en;
   logic                  dbus_rsp_valid;
   logic [31:0]           dbus_rdata;

   modport master (
      output dbus_req_valid, dbus_write, dbus_addr, dbus_wdata, dbus_byte_en,
      input  dbus_req_ready, dbus_rsp_valid, dbus_rdata
   );

   modport slave (
      input  dbus_req_valid, dbus_write, dbus_addr, dbus_wdata, dbus_byte_en,
      output dbus_req_ready, dbus_rsp_valid, dbus_rdata
   );
endinterface

// File: rtl/lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per memory op, extended load data back.
// Latency: 2 cycles minimum from request to lsu_done (1 cycle for a misaligned-access exception).
// Backpressure: o_lsu_stall holds the pipeline until the response arrives; waits on dbus_req_ready.
//
// Optional feature: define LSU_MISALIGN_EXC_EN to raise a misaligned-access exception instead of
// silently clearing the offending low address bits.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   i_lsu_mem_read    load request (held stable while o_lsu_stall=1)
//   i_lsu_mem_write   store request (never together with i_lsu_mem_read)
//   i_lsu_funct3      000 B, 001 H, 010 W, 100 BU, 101 HU; others decode as W
//   i_lsu_addr        effective address from the ALU
//   i_lsu_wdata       store data (rs2)
//   o_lsu_stall       request present and not yet done
//   o_lsu_done        one-cycle completion pulse
//   o_lsu_rdata       extended load data, 0 unless a load completes this cycle
//   o_lsu_misalign    misaligned-access exception, pulses with o_lsu_done
//   dbus              data bus, master side
module lsu #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_lsu_mem_read,
   input  logic                  i_lsu_mem_write,
   input  logic [2:0]            i_lsu_funct3,
   input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
   input  logic [31:0]           i_lsu_wdata,
   output logic                  o_lsu_stall,
   output logic                  o_lsu_done,
   output logic [31:0]           o_lsu_rdata,
   output logic                  o_lsu_misalign,
   lsu_if.master                 dbus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
`ifdef LSU_MISALIGN_EXC_EN
   localparam logic [1:0] S_EXC  = 2'd3;
`endif

   logic [1:0]            r_state;
   logic [1:0]            r_addr_lo;
   logic [2:0]            r_funct3;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_bus_addr;
   logic [31:0]           r_bus_wdata;
   logic [3:0]            r_bus_be;

   logic                  w_req;
   logic                  w_go_req;
   logic                  w_is_b;
   logic                  w_is_h;
   logic [1:0]            w_addr_lo;
   logic [3:0]            w_be;
   logic [31:0]           w_wdata;
   logic                  w_rsp_done;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_ext;

   assign w_req  = i_lsu_mem_read | i_lsu_mem_write;
   assign w_is_b = (i_lsu_funct3[1:0] == 2'b00);
   assign w_is_h = (i_lsu_funct3[1:0] == 2'b01);

   // Low address bits rounded down to the access size. Any difference from the
   // raw bits means the access is misaligned.
   always_comb begin
      w_addr_lo = 2'b00;
      if (w_is_b) begin
         w_addr_lo = i_lsu_addr[1:0];
      end else if (w_is_h) begin
         w_addr_lo = {i_lsu_addr[1], 1'b0};
      end
   end

`ifdef LSU_MISALIGN_EXC_EN
   logic w_misal;
   assign w_misal  = (w_addr_lo != i_lsu_addr[1:0]);
   assign w_go_req = w_req & ~w_misal;
`else
   assign w_go_req = w_req;
`endif

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_lsu_wdata;
      if (w_is_b) begin
         w_be    = 4'b0001 << w_addr_lo;
         w_wdata = {4{i_lsu_wdata[7:0]}};
      end else if (w_is_h) begin
         w_be    = 4'b0011 << w_addr_lo;
         w_wdata = {2{i_lsu_wdata[15:0]}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr_lo   <= 2'b00;
         r_funct3    <= 3'b000;
         r_write     <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= 32'h0;
         r_bus_be    <= 4'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go_req) begin
                  r_state     <= S_REQ;
                  r_write     <= i_lsu_mem_write;
                  r_funct3    <= i_lsu_funct3;
                  r_addr_lo   <= w_addr_lo;
                  r_bus_addr  <= {i_lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                  r_bus_wdata <= w_wdata;
                  r_bus_be    <= w_be;
               end
`ifdef LSU_MISALIGN_EXC_EN
               else if (w_req) begin
                  r_state <= S_EXC;
               end
`endif
            end
            S_REQ: begin
               // A response in the acceptance cycle is illegal on this bus and ignored.
               if (dbus.dbus_req_ready) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dbus.dbus_rsp_valid) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Load lane selection and extension from the registered access.
   always_comb begin
      w_byte = dbus.dbus_rdata[7:0];
      case (r_addr_lo)
         2'd1:    w_byte = dbus.dbus_rdata[15:8];
         2'd2:    w_byte = dbus.dbus_rdata[23:16];
         2'd3:    w_byte = dbus.dbus_rdata[31:24];
         default: w_byte = dbus.dbus_rdata[7:0];
      endcase
      w_half = r_addr_lo[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
      case (r_funct3[1:0])
         2'b00:   w_ext = r_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_ext = r_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ext = dbus.dbus_rdata;
      endcase
   end

   assign w_rsp_done = (r_state == S_WAIT) & dbus.dbus_rsp_valid;

`ifdef LSU_MISALIGN_EXC_EN
   assign o_lsu_done     = w_rsp_done | (r_state == S_EXC);
   assign o_lsu_misalign = (r_state == S_EXC);
`else
   assign o_lsu_done     = w_rsp_done;
   assign o_lsu_misalign = 1'b0;
`endif

   assign o_lsu_rdata = (w_rsp_done & ~r_write) ? w_ext : 32'h0;
   assign o_lsu_stall = w_req & ~o_lsu_done;

   assign dbus.dbus_req_valid = (r_state == S_REQ);
   assign dbus.dbus_write     = r_write;
   assign dbus.dbus_addr      = r_bus_addr;
   assign dbus.dbus_wdata     = r_bus_wdata;
   assign dbus.dbus_byte_en   = r_bus_be;

endmodule
